// File: rtl/freq_pkg.sv
// Shared types and constants for the square-wave frequency generator.
package freq_pkg;

  localparam int unsigned FREQ_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, done after DIV_W iterations.
module seq_divider #(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [16:0]      divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DIV_W + 1);

  logic             busy;
  logic [CNT_W-1:0] iter;
  logic [16:0]      rem;
  logic [16:0]      dvs;
  logic [17:0]      trial;

  // quotient doubles as the dividend shift register
  assign trial = {rem, quotient[DIV_W-1]};
  assign done  = busy && (iter == CNT_W'(DIV_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      iter     <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      iter     <= '0;
      rem      <= '0;
      dvs      <= divisor;
      quotient <= dividend;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      iter <= iter + CNT_W'(1);
      if (trial >= {1'b0, dvs}) begin
        rem      <= 17'(trial - {1'b0, dvs});
        quotient <= {quotient[DIV_W-2:0], 1'b1};
      end else begin
        rem      <= trial[16:0];
        quotient <= {quotient[DIV_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/freq_generator.sv
// Programmable 50%-duty square-wave generator; half period = CLK_HZ / (2*freq_in).
// Optional FREQ_GEN_GATE_EN adds a gate input that parks the output low between high phases.
module freq_generator
  import freq_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned DIV_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef FREQ_GEN_GATE_EN
  input  logic              gate,
`endif
  input  logic [FREQ_W-1:0] freq_in,
  input  logic              freq_valid,
  output logic              freq_ready,
  output logic              sig_out,
  output logic              period_tick,
  output logic [FREQ_W-1:0] cur_freq
);

  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ);

  state_t            state, state_nx;
  logic              accept, start, done, wave_on, wrap, stop_go, gate_i;
  logic              launch, stop_pend, pend, hold;
  logic [DIV_W-1:0]  quot, h_div, h_cur, h_pend, cnt;
  logic [FREQ_W-1:0] f_req;

`ifdef FREQ_GEN_GATE_EN
  assign gate_i = gate;
`else
  assign gate_i = 1'b1;
`endif

  seq_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (DIVIDEND),
    .divisor  ({freq_in, 1'b0}),
    .done     (done),
    .quotient (quot)
  );

  assign h_div = (quot == '0) ? DIV_W'(1) : quot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    freq_ready = (state != DIV);
    accept     = freq_valid && freq_ready;
    start      = accept && (freq_in != '0);
    wrap       = (cnt == h_cur - DIV_W'(1));
    stop_go    = (state == RUN) && stop_pend && (!sig_out || wrap);
    // while re-dividing from RUN the old waveform keeps running
    wave_on    = (state == RUN) || ((state == DIV) && !launch);
    case (state)
      IDLE:    if (start) state_nx = DIV;
      DIV:     if (done) state_nx = RUN;
      RUN: begin
        if (start)        state_nx = DIV;
        else if (stop_go) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_out     <= 1'b0;
      period_tick <= 1'b0;
      cur_freq    <= '0;
      f_req       <= '0;
      h_cur       <= '0;
      h_pend      <= '0;
      cnt         <= '0;
      launch      <= 1'b0;
      stop_pend   <= 1'b0;
      pend        <= 1'b0;
      hold        <= 1'b0;
    end else begin
      period_tick <= 1'b0;
      if (accept) begin
        if (freq_in == '0) begin
          stop_pend <= (state == RUN);
        end else begin
          f_req     <= freq_in;
          launch    <= (state == IDLE) || stop_go;
          stop_pend <= 1'b0;
          pend      <= 1'b0;
        end
      end
      if (done) begin
        if (launch) begin
          h_cur    <= h_div;
          cur_freq <= f_req;
          hold     <= 1'b1;
          cnt      <= '0;
        end else begin
          h_pend <= h_div;
          pend   <= 1'b1;
        end
      end
      // hold: output parked low, rises on the next cycle the gate allows
      if (wave_on) begin
        if (stop_go) begin
          sig_out   <= 1'b0;
          cur_freq  <= '0;
          stop_pend <= 1'b0;
          pend      <= 1'b0;
          hold      <= 1'b0;
          cnt       <= '0;
        end else if (!sig_out && (hold || !gate_i)) begin
          if (gate_i) begin
            sig_out     <= 1'b1;
            period_tick <= 1'b1;
            hold        <= 1'b0;
            cnt         <= '0;
          end else begin
            hold <= 1'b1;
          end
        end else if (wrap) begin
          cnt     <= '0;
          sig_out <= !sig_out;
          if (!sig_out) begin
            period_tick <= 1'b1;
          end else if (pend) begin
            h_cur    <= h_pend;
            cur_freq <= f_req;
            pend     <= 1'b0;
          end
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_generator.sv
// Directed bench for freq_generator at CLK_HZ=1000; gate scenario runs when FREQ_GEN_GATE_EN is defined.
module tb_freq_generator;
  import freq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freq_valid = 1'b0;
  logic [15:0] freq_in = '0;
  logic        freq_ready, sig_out, period_tick;
  logic [15:0] cur_freq;
`ifdef FREQ_GEN_GATE_EN
  logic        gate = 1'b1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  freq_generator #(.CLK_HZ(1000), .DIV_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef FREQ_GEN_GATE_EN
    .gate        (gate),
`endif
    .freq_in     (freq_in),
    .freq_valid  (freq_valid),
    .freq_ready  (freq_ready),
    .sig_out     (sig_out),
    .period_tick (period_tick),
    .cur_freq    (cur_freq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [15:0] f);
    freq_in    = f;
    freq_valid = 1'b1;
    @(negedge clk);
    freq_valid = 1'b0;
    c0 = cyc;
  endtask

  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (sig_out === lvl && len < 200) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rise(output int dly);
    int k = 0;
    while (sig_out !== 1'b1 && k < 100) begin
      k++;
      @(negedge clk);
    end
    dly = cyc - c0;
  endtask

  task automatic ready_low(output int len);
    len = 0;
    while (freq_ready === 1'b0 && len < 100) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic count_high(input int cycles, output int highs);
    highs = 0;
    repeat (cycles) begin
      if (sig_out !== 1'b0 || period_tick !== 1'b0) highs++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sig_out", sig_out, 0);
    check("rst_tick", period_tick, 0);
    check("rst_ready", freq_ready, 1);
    check("rst_cur_freq", cur_freq, 0);
    check("rst_state", dut.state, IDLE);
    rst_n = 1'b1;

    // zero request from IDLE does nothing
    request(16'd0);
    check("idle_stop_ready", freq_ready, 1);
    count_high(40, n);
    check("idle_stop_quiet", n, 0);
    check("idle_stop_state", dut.state, IDLE);

    // 100 Hz from IDLE, with an ignored request during the divide
    request(16'd100);
    check("t100_ready_low", freq_ready, 0);
    freq_in    = 16'd600;
    freq_valid = 1'b1;
    @(negedge clk);
    freq_valid = 1'b0;
    freq_in    = '0;
    wait_rise(n);
    check("t100_rise_dly", n, 34);
    check("t100_tick_rise", period_tick, 1);
    check("t100_cur_freq", cur_freq, 100);
    run_len(1'b1, n);
    check("t100_high1", n, 5);
    check("t100_tick_low", period_tick, 0);
    run_len(1'b0, n);
    check("t100_low1", n, 5);
    check("t100_tick_rise2", period_tick, 1);
    run_len(1'b1, n);
    check("t100_high2", n, 5);

    // retune to 50 Hz early in a high phase
    run_len(1'b0, n);
    check("t50_low_before", n, 5);
    request(16'd50);
    ready_low(n);
    check("t50_ready_low_len", n, 33);
    check("t50_sig_at_done", sig_out, 1);
    check("t50_freq_at_done", cur_freq, 100);
    run_len(1'b1, n);
    check("t50_old_high_tail", n, 1);
    check("t50_cur_freq", cur_freq, 50);
    run_len(1'b0, n);
    check("t50_low", n, 10);
    run_len(1'b1, n);
    check("t50_high", n, 10);

    // stop during a high phase
    run_len(1'b0, n);
    check("stop_low_before", n, 10);
    request(16'd0);
    check("stop_ready", freq_ready, 1);
    run_len(1'b1, n);
    check("stop_high_tail", n, 9);
    check("stop_cur_freq", cur_freq, 0);
    check("stop_state", dut.state, IDLE);
    count_high(30, n);
    check("stop_quiet", n, 0);

    // 600 Hz clamps the half period to one cycle
    request(16'd600);
    wait_rise(n);
    check("t600_rise_dly", n, 34);
    check("t600_cur_freq", cur_freq, 600);
    run_len(1'b1, n);
    check("t600_high", n, 1);
    run_len(1'b0, n);
    check("t600_low", n, 1);
    check("t600_tick", period_tick, 1);
    run_len(1'b1, n);
    check("t600_high2", n, 1);
    request(16'd0);
    repeat (3) @(negedge clk);
    check("t600_stop_sig", sig_out, 0);
    check("t600_stop_freq", cur_freq, 0);
    check("t600_stop_state", dut.state, IDLE);

    // reset in the middle of a divide
    request(16'd100);
    repeat (10) @(negedge clk);
    check("rdiv_busy", freq_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rdiv_async_ready", freq_ready, 1);
    @(negedge clk);
    check("rdiv_sig", sig_out, 0);
    check("rdiv_tick", period_tick, 0);
    check("rdiv_cur_freq", cur_freq, 0);
    check("rdiv_state", dut.state, IDLE);
    rst_n = 1'b1;
    request(16'd100);
    check("rdiv_accept", freq_ready, 0);
    wait_rise(n);
    check("rdiv_rise_dly", n, 34);
    check("rdiv_cur_freq2", cur_freq, 100);
    run_len(1'b1, n);
    check("rdiv_high", n, 5);
    run_len(1'b0, n);
    check("rdiv_low", n, 5);

`ifdef FREQ_GEN_GATE_EN
    gate = 1'b0;
    run_len(1'b1, n);
    check("gate_high_full", n, 5);
    count_high(20, n);
    check("gate_parked", n, 0);
    gate = 1'b1;
    @(negedge clk);
    check("gate_restart_sig", sig_out, 1);
    check("gate_restart_tick", period_tick, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_generator.md
FREQ_GENERATOR -- requirements
Module: freq_generator

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, frequency of clk in Hz (2..2^32-1).
REQ-002 SHALL have parameter DIV_W, default 32, width of half-period counter and divider quotient.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port freq_in  input  16  requested output frequency in Hz.
REQ-006 SHALL have port freq_valid  input  1  request qualifier for freq_in.
REQ-007 SHALL have port freq_ready  output  1  block can accept a request.
REQ-008 SHALL have port sig_out  output  1  generated square wave, 50% duty.
REQ-009 SHALL have port period_tick  output  1  one-cycle pulse coincident with each sig_out 0->1 transition.
REQ-010 SHALL have port cur_freq  output  16  frequency currently being generated, 0 when stopped.

Function
REQ-011 SHALL accept a request on a clk edge where freq_valid and freq_ready are both 1; freq_in is sampled on that edge only.
REQ-012 SHALL use states IDLE (stopped, sig_out=0), DIV (divider busy), RUN (toggling); freq_ready=1 in IDLE and RUN, 0 in DIV.
REQ-013 SHALL compute half-period H = floor(CLK_HZ / (2*freq_in)) with a DIV_W-iteration sequential restoring divide, clamping H to 1 when the quotient is 0.
REQ-014 SHALL complete the divide exactly DIV_W+1 cycles after the accept edge.
REQ-015 SHALL, from IDLE, drive sig_out=1 and pulse period_tick on the cycle after divide completion, then enter RUN.
REQ-016 SHALL in RUN toggle sig_out every H cycles using a counter that counts 0..H-1 and wraps.
REQ-017 SHALL, when a new request is accepted in RUN, keep toggling with the old H during DIV and apply the new H only at the next 1->0 transition of sig_out (glitch-free, no short high phase).
REQ-018 SHALL update cur_freq on the same cycle the new H takes effect.
REQ-019 SHALL treat freq_in=0 as stop: no divide; from RUN, finish the current high phase, drive sig_out=0 at its natural falling edge, set cur_freq=0, go IDLE; from IDLE, no effect.
REQ-020 SHALL ignore freq_valid while in DIV (no queuing).

Reset
REQ-021 SHALL, while rst_n=0, force state IDLE, sig_out=0, period_tick=0, freq_ready=1, cur_freq=0, counter and divider cleared.
REQ-022 SHALL abandon any divide or waveform in progress when reset asserts mid-operation; first accept is possible on the first clk edge after rst_n deasserts.

Configuration
REQ-023 SHALL, with FREQ_GEN_GATE_EN defined, add input gate (1 bit): gate=0 makes sig_out finish its current high phase, then hold 0 with counter held and no period_tick; gate 0->1 restarts with sig_out=1 on the next cycle.
REQ-024 SHALL, without FREQ_GEN_GATE_EN, have no gate port and behave as gate=1.

Structure
REQ-025 SHALL place the state encoding (IDLE/DIV/RUN) and the 16-bit frequency width constant in shared package freq_pkg.
REQ-026 SHALL implement the divide in sub-module seq_divider (start/done handshake, DIV_W-bit dividend, 17-bit divisor, DIV_W-bit quotient).

Verification
REQ-027 SHALL cover: CLK_HZ=1000, freq_in=100 from IDLE -> sig_out rises 34 cycles after accept, then high 5 / low 5 cycles, cur_freq=100.
REQ-028 SHALL cover: CLK_HZ=1000, freq_in=600 -> H clamped to 1, sig_out toggles every cycle, cur_freq=600.
REQ-029 SHALL cover: running at 100 Hz, request 50 Hz mid-high-phase -> old 5/5 timing kept until next falling edge, then 10/10, freq_ready=0 for exactly 33 cycles.
REQ-030 SHALL cover: running, freq_in=0 accepted during high phase -> high phase completes at full length, sig_out=0 thereafter, cur_freq=0, state IDLE.
REQ-031 SHALL cover: rst_n pulsed low during DIV -> all outputs at reset values, new request of 100 Hz afterwards produces REQ-027 timing.
REQ-032 SHALL cover (FREQ_GEN_GATE_EN): gate=0 during high phase at 100 Hz -> sig_out falls at natural edge and stays 0, no period_tick; gate=1 -> sig_out=1 next cycle with period_tick.
